bullet_manager: RTL and testbench
=================================

// Module: bullet_manager
// PURPOSE
//  Consumes ShootBullet/TankX/TankY/sin/cos from one tank controller; owns a pool of bullets.
//  Spawns a bullet on each accepted fire request and moves it once per frame.
//  Bounces bullets off the screen bounds, retires them after a fixed lifetime, and flags opponent-tank hits.
//  Bullet positions feed the colour mapper; OppHit feeds game-end scoring logic.
// PARAMETERS
//  MAX_BULLETS  4    bullet slots; slot 0 has highest allocation priority
//  LIFETIME     255  frames a bullet lives (8-bit counter)
//  COOLDOWN     15   frames after a spawn during which fire requests are ignored
//  SPEED        8    velocity scale; |v| (eighth-pixels/frame) = (mag*SPEED)>>5
//  X_MIN/X_MAX  0/639  horizontal bounce bounds, pixels
//  Y_MIN/Y_MAX  0/479  vertical bounce bounds, pixels
// PORTS
//  frame_clk    in   1   frame clock (vsync rate); all state updates on its rising edge
//  Reset        in   1   asynchronous, active-high reset
//  game_end     in   2   nonzero: clear all bullets, synchronously
//  ShootBullet  in   1   fire level from tank; rising edge requests a bullet
//  TankX,TankY  in   10  spawn point, pixels
//  sin,cos      in   8   sign-magnitude heading: [7]=sign, [6:0]=mag (127 = 1.0)
//  OppX,OppY    in   10  opponent tank centre, pixels
//  OppS         in   10  opponent tank half-size, pixels
//  BulletX      out  10*MAX_BULLETS  slot i at [10i+9:10i]; integer pixel (pos_q>>3)
//  BulletY      out  10*MAX_BULLETS  as BulletX
//  BulletActive out  MAX_BULLETS     slot i live
//  OppHit       out  1   one-frame pulse: a live bullet hit the opponent
//  Fired        out  1   one-frame pulse: a bullet was spawned this edge
// BEHAVIOUR
//  Reset: all slots inactive, all pos/vel/life 0, cooldown 0, shoot_prev 0, OppHit=Fired=0,
//   BulletX/BulletY=0. Mid-flight reset kills every bullet immediately.
//  Per slot: x_q,y_q 13-bit unsigned Q10.3; vx,vy 9-bit signed eighth-px/frame; life 8-bit.
//  Velocity: vmag = (mag*SPEED)>>5. cos[7]=0 -> +X; sin[7]=0 -> -Y (screen up), i.e. vy=-vmag.
//  Fire accept: ShootBullet=1 && shoot_prev=0 && cooldown==0 && any slot free.
//   Lowest free slot loads x_q=TankX<<3, y_q=TankY<<3, vel from sin/cos sampled that edge, life=LIFETIME;
//   cooldown=COOLDOWN; Fired=1. Visible on outputs after that edge; not moved until the next edge.
//   No free slot or cooldown>0: request dropped, not queued. Held button fires once.
//  shoot_prev <= ShootBullet every edge. cooldown decrements to 0 and saturates.
//  Per live slot, per edge, priority order:
//   1 game_end!=0 -> inactive (all slots; also no spawn, OppHit=0, cooldown=0).
//   2 Hit: |(x_q>>3)-OppX|<=OppS and |(y_q>>3)-OppY|<=OppS, on registered pos -> inactive, OppHit=1.
//   3 life==1 -> inactive; otherwise life-1.
//   4 Move: nx = x_q+vx (14-bit signed). If nx<X_MIN<<3: x_q=X_MIN<<3, vx=-vx.
//     If nx>X_MAX<<3: x_q=X_MAX<<3, vx=-vx. Else x_q=nx. Y identical with Y bounds.
//  Multiple hits in one edge: OppHit still a single 1-frame pulse; all hitting slots retire.
//  A slot freed and a fire request on the same edge: freed slot not reusable until the next edge.
//  Inactive slots hold last position; consumers must gate on BulletActive.
//  Outputs are registered; total latency input edge -> output: 1 frame.
// TESTING
//  T1 Reset while 2 bullets live -> BulletActive=0, OppHit=0, Fired=0 immediately (async).
//  T2 TankX=300,TankY=250,cos=8'h7F,sin=0, ShootBullet 0->1 -> Fired=1, slot0 at (300,250);
//     after 8 more frames BulletX=331 (2400+8*31=2648), BulletY=250.
//  T3 ShootBullet held 40 frames -> exactly 1 spawn; pulse 4 times spaced >COOLDOWN ->
//     slots 0..3 fill; 5th pulse -> Fired=0, no change.
//  T4 Bullet x=638, vx=+31 -> next frame BulletX=639, vx=-31; following frame BulletX=635.
//  T5 Single bullet, no hit, no bounce -> active exactly LIFETIME=255 frames, then inactive.
//  T6 OppX=320,OppY=250,OppS=10, bullet reaches x=310 -> OppHit=1 one frame, slot freed;
//     game_end=2 with 3 live bullets -> all inactive next edge, ShootBullet edge ignored.

Source files
------------

// File: rtl/bullet_manager.sv
// Bullet pool for one tank: spawns on fire edges, moves once per frame, bounces off the
// screen bounds, retires on lifetime expiry or opponent hit.
module bullet_manager #(
  parameter int MAX_BULLETS = 4,
  parameter int LIFETIME    = 255,
  parameter int COOLDOWN    = 15,
  parameter int SPEED       = 8,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 639,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 479
) (
  input  logic                      frame_clk,
  input  logic                      Reset,
  input  logic [1:0]                game_end,
  input  logic                      ShootBullet,
  input  logic [9:0]                TankX,
  input  logic [9:0]                TankY,
  input  logic [7:0]                sin,
  input  logic [7:0]                cos,
  input  logic [9:0]                OppX,
  input  logic [9:0]                OppY,
  input  logic [9:0]                OppS,
  output logic [10*MAX_BULLETS-1:0] BulletX,
  output logic [10*MAX_BULLETS-1:0] BulletY,
  output logic [MAX_BULLETS-1:0]    BulletActive,
  output logic                      OppHit,
  output logic                      Fired
);

  localparam logic [12:0] X_LO      = 13'(X_MIN * 8);
  localparam logic [12:0] X_HI      = 13'(X_MAX * 8);
  localparam logic [12:0] Y_LO      = 13'(Y_MIN * 8);
  localparam logic [12:0] Y_HI      = 13'(Y_MAX * 8);
  localparam logic [7:0]  LIFE_INIT = 8'(LIFETIME);
  localparam logic [7:0]  COOL_INIT = 8'(COOLDOWN);

  logic [12:0]        x_q    [MAX_BULLETS];
  logic [12:0]        x_n    [MAX_BULLETS];
  logic [12:0]        y_q    [MAX_BULLETS];
  logic [12:0]        y_n    [MAX_BULLETS];
  logic signed [8:0]  vx_q   [MAX_BULLETS];
  logic signed [8:0]  vx_n   [MAX_BULLETS];
  logic signed [8:0]  vy_q   [MAX_BULLETS];
  logic signed [8:0]  vy_n   [MAX_BULLETS];
  logic [7:0]         life_q [MAX_BULLETS];
  logic [7:0]         life_n [MAX_BULLETS];
  logic [MAX_BULLETS-1:0] active_q;
  logic [MAX_BULLETS-1:0] active_n;
  logic [7:0]         cool_q;
  logic [7:0]         cool_n;
  logic               shoot_prev;
  logic               accept;
  logic               taken;
  logic               hit_n;
  logic [21:0]        x_step;
  logic [21:0]        y_step;

  // Sign-magnitude heading component to signed eighth-pixel velocity.
  function automatic logic signed [8:0] heading_vel(input logic [7:0] sm, input logic invert);
    logic signed [8:0] mag;
    mag = $signed({1'b0, 8'((16'(sm[6:0]) * 16'(SPEED)) >> 5)});
    return (sm[7] ^ invert) ? -mag : mag;
  endfunction

  // One axis step: returns {position, velocity}, clamping to the bound and reflecting.
  function automatic logic [21:0] bounce(input logic [12:0] pos, input logic signed [8:0] vel,
                                         input logic [12:0] lo, input logic [12:0] hi);
    logic signed [13:0] nxt;
    nxt = $signed({1'b0, pos}) + $signed({{5{vel[8]}}, vel});
    if (nxt < $signed({1'b0, lo}))
      return {lo, -vel};
    else if (nxt > $signed({1'b0, hi}))
      return {hi, -vel};
    return {nxt[12:0], vel};
  endfunction

  function automatic logic near(input logic [9:0] p, input logic [9:0] c, input logic [9:0] s);
    logic signed [10:0] d;
    d = $signed({1'b0, p}) - $signed({1'b0, c});
    return (d[10] ? $unsigned(-d) : $unsigned(d)) <= {1'b0, s};
  endfunction

  always_comb begin
    x_n      = x_q;
    y_n      = y_q;
    vx_n     = vx_q;
    vy_n     = vy_q;
    life_n   = life_q;
    active_n = active_q;
    hit_n    = 1'b0;
    taken    = 1'b0;
    x_step   = '0;
    y_step   = '0;
    // Occupancy is judged on registered state, so a slot freed this edge is not reused.
    accept = ShootBullet && !shoot_prev && (cool_q == 8'd0) && (game_end == 2'd0) && !(&active_q);

    for (int i = 0; i < MAX_BULLETS; i++) begin
      if (game_end != 2'd0) begin
        active_n[i] = 1'b0;
      end else if (active_q[i]) begin
        if (near(x_q[i][12:3], OppX, OppS) && near(y_q[i][12:3], OppY, OppS)) begin
          active_n[i] = 1'b0;
          hit_n       = 1'b1;
        end else if (life_q[i] == 8'd1) begin
          active_n[i] = 1'b0;
        end else begin
          life_n[i] = life_q[i] - 8'd1;
          x_step    = bounce(x_q[i], vx_q[i], X_LO, X_HI);
          y_step    = bounce(y_q[i], vy_q[i], Y_LO, Y_HI);
          x_n[i]    = x_step[21:9];
          vx_n[i]   = $signed(x_step[8:0]);
          y_n[i]    = y_step[21:9];
          vy_n[i]   = $signed(y_step[8:0]);
        end
      end else if (accept && !taken) begin
        taken       = 1'b1;
        active_n[i] = 1'b1;
        x_n[i]      = {TankX, 3'b000};
        y_n[i]      = {TankY, 3'b000};
        vx_n[i]     = heading_vel(cos, 1'b0);
        vy_n[i]     = heading_vel(sin, 1'b1);
        life_n[i]   = LIFE_INIT;
      end
    end

    if (game_end != 2'd0)
      cool_n = 8'd0;
    else if (accept)
      cool_n = COOL_INIT;
    else if (cool_q != 8'd0)
      cool_n = cool_q - 8'd1;
    else
      cool_n = cool_q;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < MAX_BULLETS; i++) begin
        x_q[i]    <= '0;
        y_q[i]    <= '0;
        vx_q[i]   <= '0;
        vy_q[i]   <= '0;
        life_q[i] <= '0;
      end
      active_q   <= '0;
      cool_q     <= '0;
      shoot_prev <= 1'b0;
      OppHit     <= 1'b0;
      Fired      <= 1'b0;
    end else begin
      x_q        <= x_n;
      y_q        <= y_n;
      vx_q       <= vx_n;
      vy_q       <= vy_n;
      life_q     <= life_n;
      active_q   <= active_n;
      cool_q     <= cool_n;
      shoot_prev <= ShootBullet;
      OppHit     <= hit_n;
      Fired      <= accept;
    end
  end

  assign BulletActive = active_q;

  for (genvar g = 0; g < MAX_BULLETS; g++) begin : g_out
    assign BulletX[10*g +: 10] = x_q[g][12:3];
    assign BulletY[10*g +: 10] = y_q[g][12:3];
  end

endmodule

// File: tb/tb_bullet_manager.sv
// Directed bench for bullet_manager: spawn, cooldown, slot fill, bounce, lifetime, hit, game end.
module tb_bullet_manager;

  logic        frame_clk = 1'b0;
  logic        Reset = 1'b1;
  logic [1:0]  game_end = '0;
  logic        ShootBullet = 1'b0;
  logic [9:0]  TankX = '0, TankY = '0;
  logic [7:0]  sin = '0, cos = '0;
  logic [9:0]  OppX = 10'd1023, OppY = 10'd1023, OppS = '0;
  logic [39:0] BulletX, BulletY;
  logic [3:0]  BulletActive;
  logic        OppHit, Fired;

  int checks = 0;
  int failures = 0;
  int fires;

  always #5 frame_clk = ~frame_clk;

  bullet_manager dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .game_end    (game_end),
    .ShootBullet (ShootBullet),
    .TankX       (TankX),
    .TankY       (TankY),
    .sin         (sin),
    .cos         (cos),
    .OppX        (OppX),
    .OppY        (OppY),
    .OppS        (OppS),
    .BulletX     (BulletX),
    .BulletY     (BulletY),
    .BulletActive(BulletActive),
    .OppHit      (OppHit),
    .Fired       (Fired)
  );

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    ShootBullet = 1'b0;
    game_end    = 2'd0;
    OppX = 10'd1023; OppY = 10'd1023; OppS = 10'd0;
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
  endtask

  initial begin
    // Power-up reset held across edges
    tick(2);
    chk("rst_active", 40'(BulletActive), 40'd0);
    chk("rst_opphit", 40'(OppHit), 40'd0);
    chk("rst_fired", 40'(Fired), 40'd0);
    chk("rst_bx", BulletX, 40'd0);
    chk("rst_by", BulletY, 40'd0);
    Reset = 1'b0;

    // T2: spawn and straight flight, vx = (127*8)>>5 = 31
    TankX = 10'd300; TankY = 10'd250; cos = 8'h7F; sin = 8'h00;
    ShootBullet = 1'b1;
    tick(1);
    chk("t2_fired", 40'(Fired), 40'd1);
    chk("t2_active", 40'(BulletActive), 40'b0001);
    chk("t2_x0", 40'(BulletX[9:0]), 40'd300);
    chk("t2_y0", 40'(BulletY[9:0]), 40'd250);
    ShootBullet = 1'b0;
    tick(1);
    chk("t2_fired_pulse", 40'(Fired), 40'd0);
    chk("t2_x1", 40'(BulletX[9:0]), 40'd303);
    tick(7);
    chk("t2_x8", 40'(BulletX[9:0]), 40'd331);
    chk("t2_y8", 40'(BulletY[9:0]), 40'd250);

    // Second bullet after cooldown, then async reset mid-flight (T1)
    tick(8);
    ShootBullet = 1'b1;
    tick(1);
    chk("t1_fired2", 40'(Fired), 40'd1);
    chk("t1_two_live", 40'(BulletActive), 40'b0011);
    chk("t1_slot1_x", 40'(BulletX[19:10]), 40'd300);
    chk("t1_slot0_x", 40'(BulletX[9:0]), 40'd365);
    #2 Reset = 1'b1;
    #1;
    chk("t1_async_active", 40'(BulletActive), 40'd0);
    chk("t1_async_fired", 40'(Fired), 40'd0);
    chk("t1_async_opphit", 40'(OppHit), 40'd0);
    chk("t1_async_bx", BulletX, 40'd0);
    ShootBullet = 1'b0;
    Reset = 1'b0;

    // T3: held button fires once, then pulses fill the pool
    cos = 8'h00; sin = 8'h00;
    tick(1);
    ShootBullet = 1'b1;
    tick(1);
    chk("t3_first", 40'(Fired), 40'd1);
    fires = 0;
    repeat (39) begin
      tick(1);
      fires += int'(Fired);
    end
    chk("t3_held_once", 40'(fires), 40'd0);
    chk("t3_held_active", 40'(BulletActive), 40'b0001);
    for (int k = 1; k <= 3; k++) begin
      ShootBullet = 1'b0;
      tick(16);
      ShootBullet = 1'b1;
      tick(1);
      chk("t3_pulse_fired", 40'(Fired), 40'd1);
      chk("t3_pulse_active", 40'(BulletActive), 40'((1 << (k + 1)) - 1));
    end
    ShootBullet = 1'b0;
    tick(16);
    ShootBullet = 1'b1;
    tick(1);
    chk("t3_full_fired", 40'(Fired), 40'd0);
    chk("t3_full_active", 40'(BulletActive), 40'b1111);

    // T6b: game_end clears everything and swallows a fire edge
    ShootBullet = 1'b0;
    tick(20);
    game_end = 2'd2;
    ShootBullet = 1'b1;
    tick(1);
    chk("ge_active", 40'(BulletActive), 40'd0);
    chk("ge_fired", 40'(Fired), 40'd0);
    chk("ge_opphit", 40'(OppHit), 40'd0);
    game_end = 2'd0;
    tick(1);
    chk("ge_held_nofire", 40'(Fired), 40'd0);
    ShootBullet = 1'b0;
    tick(1);
    ShootBullet = 1'b1;
    tick(1);
    chk("ge_refire", 40'(Fired), 40'd1);
    chk("ge_refire_active", 40'(BulletActive), 40'b0001);

    // T4: bounce on both axes, then T5: lifetime on the same bullet
    do_reset();
    TankX = 10'd638; TankY = 10'd2; cos = 8'h7F; sin = 8'h7F;
    ShootBullet = 1'b1;
    tick(1);
    chk("t4_fired", 40'(Fired), 40'd1);
    chk("t4_x0", 40'(BulletX[9:0]), 40'd638);
    chk("t4_y0", 40'(BulletY[9:0]), 40'd2);
    ShootBullet = 1'b0;
    tick(1);
    chk("t4_x_clamp", 40'(BulletX[9:0]), 40'd639);
    chk("t4_y_clamp", 40'(BulletY[9:0]), 40'd0);
    tick(1);
    chk("t4_x_back", 40'(BulletX[9:0]), 40'd635);
    chk("t4_y_back", 40'(BulletY[9:0]), 40'd3);
    tick(1);
    chk("t4_x_back2", 40'(BulletX[9:0]), 40'd631);
    chk("t4_y_back2", 40'(BulletY[9:0]), 40'd7);
    tick(251);
    chk("t5_last_live", 40'(BulletActive), 40'b0001);
    tick(1);
    chk("t5_expired", 40'(BulletActive), 40'd0);

    // T6: opponent hit
    do_reset();
    OppX = 10'd320; OppY = 10'd250; OppS = 10'd10;
    TankX = 10'd300; TankY = 10'd250; cos = 8'h7F; sin = 8'h00;
    ShootBullet = 1'b1;
    tick(1);
    ShootBullet = 1'b0;
    tick(2);
    chk("t6_x2", 40'(BulletX[9:0]), 40'd307);
    chk("t6_nohit_yet", 40'(OppHit), 40'd0);
    tick(1);
    chk("t6_x3", 40'(BulletX[9:0]), 40'd311);
    chk("t6_live_x3", 40'(BulletActive), 40'b0001);
    chk("t6_nohit_x3", 40'(OppHit), 40'd0);
    tick(1);
    chk("t6_hit", 40'(OppHit), 40'd1);
    chk("t6_freed", 40'(BulletActive), 40'd0);
    chk("t6_hold_x", 40'(BulletX[9:0]), 40'd311);
    tick(1);
    chk("t6_hit_pulse", 40'(OppHit), 40'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
